// File: rtl/alu_issue_scheduler_if.sv
// alu_issue_scheduler_if
//   Bundles the decode-side slot signals, the branch resolution input and the
//   issue/fetch control outputs of the dual-issue scheduler.
//
//   Decode -> scheduler : valid0/1, rs0/1, rt0/1, rd0/1, use_rt0/1,
//                         regwr0/1, isbr0/1, branch_ctrl
//   Scheduler -> pipes  : issue0/1, consumed, fetch_flush, busy, stall_count
//
//   master : the decode/fetch side that presents instructions
//   slave  : the scheduler itself
interface alu_issue_scheduler_if;
    logic        valid0;
    logic        valid1;
    logic [4:0]  rs0;
    logic [4:0]  rt0;
    logic [4:0]  rs1;
    logic [4:0]  rt1;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic        use_rt0;
    logic        use_rt1;
    logic        regwr0;
    logic        regwr1;
    logic        isbr0;
    logic        isbr1;
    logic        branch_ctrl;
    logic        issue0;
    logic        issue1;
    logic [1:0]  consumed;
    logic        fetch_flush;
    logic        busy;
    logic [15:0] stall_count;

    modport master (
        output valid0, valid1, rs0, rt0, rs1, rt1, rd0, rd1,
               use_rt0, use_rt1, regwr0, regwr1, isbr0, isbr1, branch_ctrl,
        input  issue0, issue1, consumed, fetch_flush, busy, stall_count
    );

    modport slave (
        input  valid0, valid1, rs0, rt0, rs1, rt1, rd0, rd1,
               use_rt0, use_rt1, regwr0, regwr1, isbr0, isbr1, branch_ctrl,
        output issue0, issue1, consumed, fetch_flush, busy, stall_count
    );
endinterface

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler
//   In-order dual-issue scheduler feeding two forwarding-less ALU
//   subpipelines. Decides each cycle how many of the two oldest decoded
//   instructions enter ID/EX, tracks pending register writes in a countdown
//   scoreboard, serializes branches until branch_ctrl resolves, and reports
//   consumption and flush requests to the IFU.
//
//   Parameters : WB_LAT (1..4) issue-to-readable latency of a destination
//                BR_LAT (1..4) issue-to-resolution latency of a branch
//   Ports      : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                sched  slave side of alu_issue_scheduler_if
module alu_issue_scheduler #(
    parameter int WB_LAT = 3,
    parameter int BR_LAT = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    alu_issue_scheduler_if.slave  sched
);

    localparam logic [2:0] WB_LOAD = 3'(WB_LAT - 1);
    localparam logic [2:0] BR_LOAD = 3'(BR_LAT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  brCount_q;
    logic        fetchFlush_q;
    logic        busy_q;
    logic [2:0]  score_q [32];
    logic [2:0]  score_d [32];
    logic [15:0] stallCount_q;
    logic [15:0] stallCount_d;

    logic rs0Busy, rt0Busy, rs1Busy, rt1Busy;
    logic rawHazard, wawHazard;
    logic issue0, issue1;

    // A register is pending while its countdown is non-zero. Entry 0 is never
    // loaded, so reads of r0 can never look busy.
    assign rs0Busy = (score_q[sched.rs0] != 3'd0);
    assign rt0Busy = (score_q[sched.rt0] != 3'd0);
    assign rs1Busy = (score_q[sched.rs1] != 3'd0);
    assign rt1Busy = (score_q[sched.rt1] != 3'd0);

    // Slot 0 reads the scoreboard only. Slot 1 must additionally respect the
    // pair it travels with: the scoreboard cannot see slot 0's write until the
    // end of this cycle, so same-cycle RAW and WAW are checked explicitly.
    // Branches never pair with anything so the BR_WAIT serialization stays exact.
    assign rawHazard = sched.regwr0 && (sched.rd0 != 5'd0) &&
                       ((sched.rd0 == sched.rs1) ||
                        (sched.use_rt1 && (sched.rd0 == sched.rt1)));
    assign wawHazard = sched.regwr0 && sched.regwr1 &&
                       (sched.rd0 == sched.rd1) && (sched.rd0 != 5'd0);

    assign issue0 = rst_n && (state_q == RUN) && sched.valid0 &&
                    !rs0Busy && !(sched.use_rt0 && rt0Busy);

    assign issue1 = issue0 && sched.valid1 && !sched.isbr0 && !sched.isbr1 &&
                    !rs1Busy && !(sched.use_rt1 && rt1Busy) &&
                    !rawHazard && !wawHazard;

    assign sched.issue0      = issue0;
    assign sched.issue1      = issue1;
    assign sched.consumed    = {1'b0, issue0} + {1'b0, issue1};
    assign sched.fetch_flush = fetchFlush_q && rst_n;
    assign sched.busy        = busy_q;
    assign sched.stall_count = stallCount_q;

    // Next scoreboard: every pending entry counts down by one, then fresh
    // writers overwrite their entry so a reload beats the decrement. The two
    // loads can never collide because a same-destination pair is not issued.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            score_d[r] = (score_q[r] != 3'd0) ? (score_q[r] - 3'd1) : 3'd0;
        end
        if (issue0 && sched.regwr0 && (sched.rd0 != 5'd0)) begin
            score_d[sched.rd0] = WB_LOAD;
        end
        if (issue1 && sched.regwr1 && (sched.rd1 != 5'd0)) begin
            score_d[sched.rd1] = WB_LOAD;
        end
    end

    // Scoreboard storage; reset drops every in-flight write so nothing
    // stays blocked after a restart.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (!rst_n) begin
                score_q[r] <= 3'd0;
            end else begin
                score_q[r] <= score_d[r];
            end
        end
    end

    // A stalled cycle is any cycle where slot 0 holds work that cannot go,
    // whether blocked by a hazard or by branch serialization. The counter
    // sticks at all-ones instead of wrapping.
    always_comb begin
        stallCount_d = stallCount_q;
        if (sched.valid0 && !issue0 && (stallCount_q != 16'hFFFF)) begin
            stallCount_d = stallCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCount_q <= 16'd0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    // Branch serialization. Issuing a branch parks the scheduler in BR_WAIT
    // for BR_LAT cycles; branch_ctrl is looked at only in the last of them.
    // busy and fetch_flush are registered alongside the state so they reflect
    // the state being entered, not the one being left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            brCount_q    <= 3'd0;
            fetchFlush_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (issue0 && sched.isbr0) begin
                        state_q   <= BR_WAIT;
                        brCount_q <= BR_LOAD;
                        busy_q    <= 1'b1;
                    end
                end
                BR_WAIT: begin
                    brCount_q <= brCount_q - 3'd1;
                    if (brCount_q == 3'd1) begin
                        if (sched.branch_ctrl) begin
                            state_q      <= FLUSH;
                            fetchFlush_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            state_q      <= RUN;
                            fetchFlush_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_q      <= RUN;
                    fetchFlush_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= RUN;
                    fetchFlush_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb_alu_issue_scheduler
//   Drives the scheduler with directed scenarios and random traffic. A
//   time-based reference model (register ready times, branch issue cycle)
//   predicts every cycle's outputs into a queue; an independent monitor pops
//   and compares on the falling edge. A second instance with BR_LAT=4 is run
//   concurrently into stall-counter saturation.
module tb_alu_issue_scheduler;

    localparam int WB_LAT = 3;
    localparam int BR_LAT = 2;
    localparam int SAT_BR_LAT = 4;

    typedef struct {
        bit       rst;
        bit       v0, v1;
        bit [4:0] rs0, rt0, rd0, rs1, rt1, rd1;
        bit       ut0, ut1, wr0, wr1, br0, br1;
        bit       bc;
    } stim_t;

    typedef struct {
        bit        i0, i1;
        bit [1:0]  cons;
        bit        ff, bsy;
        bit [15:0] stall;
        bit        known;
    } exp_t;

    logic clk;
    logic rst_n;
    logic satRst_n;

    alu_issue_scheduler_if bus ();
    alu_issue_scheduler_if satBus ();

    alu_issue_scheduler #(.WB_LAT(WB_LAT), .BR_LAT(BR_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sched (bus)
    );

    alu_issue_scheduler #(.WB_LAT(WB_LAT), .BR_LAT(SAT_BR_LAT)) satDut (
        .clk   (clk),
        .rst_n (satRst_n),
        .sched (satBus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   errors = 0;
    int   checks = 0;
    int   monCycle = 0;
    bit   satDone = 1'b0;
    exp_t expQ[$];

    // Reference model state: the cycle number at which each register becomes
    // readable, the cycle a branch issued in, and the cycle of a pending flush.
    int cyc = 0;
    int readyAt[32];
    int brCycle = -1;
    int flushCycle = -1;
    int mStall = 0;
    bit mKnown = 1'b0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, monCycle, act, exp);
        end
    endtask

    function automatic bit regReady(input bit [4:0] r);
        return (r == 5'd0) || (cyc >= readyAt[r]);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.v0 = 1'b0; s.v1 = 1'b0;
        s.rs0 = '0; s.rt0 = '0; s.rd0 = '0; s.rs1 = '0; s.rt1 = '0; s.rd1 = '0;
        s.ut0 = 1'b0; s.ut1 = 1'b0; s.wr0 = 1'b0; s.wr1 = 1'b0;
        s.br0 = 1'b0; s.br1 = 1'b0; s.bc = 1'b0;
        return s;
    endfunction

    // Two R-type ALU ops: rd = rs op rt, both reading rt and writing rd.
    function automatic stim_t pair(input bit v0, input int rd0, input int rs0, input int rt0,
                                   input bit v1, input int rd1, input int rs1, input int rt1);
        stim_t s = idle();
        s.v0 = v0; s.rd0 = 5'(rd0); s.rs0 = 5'(rs0); s.rt0 = 5'(rt0); s.ut0 = 1'b1; s.wr0 = 1'b1;
        s.v1 = v1; s.rd1 = 5'(rd1); s.rs1 = 5'(rs1); s.rt1 = 5'(rt1); s.ut1 = 1'b1; s.wr1 = 1'b1;
        return s;
    endfunction

    // Drive one cycle of inputs just after the rising edge, predict the
    // outputs for that cycle, then advance the model to the next cycle.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit inBrWait, inFlush, running, i0, i1, raw, waw;
        @(posedge clk);
        #1;
        rst_n = s.rst;
        bus.valid0 = s.v0; bus.valid1 = s.v1;
        bus.rs0 = s.rs0; bus.rt0 = s.rt0; bus.rd0 = s.rd0;
        bus.rs1 = s.rs1; bus.rt1 = s.rt1; bus.rd1 = s.rd1;
        bus.use_rt0 = s.ut0; bus.use_rt1 = s.ut1;
        bus.regwr0 = s.wr0; bus.regwr1 = s.wr1;
        bus.isbr0 = s.br0; bus.isbr1 = s.br1;
        bus.branch_ctrl = s.bc;

        inBrWait = (brCycle >= 0) && (cyc > brCycle) && (cyc <= brCycle + BR_LAT);
        inFlush  = (cyc == flushCycle);
        running  = !inBrWait && !inFlush;
        i0  = s.rst && running && s.v0 && regReady(s.rs0) && (!s.ut0 || regReady(s.rt0));
        raw = s.wr0 && (s.rd0 != 0) && ((s.rd0 == s.rs1) || (s.ut1 && (s.rd0 == s.rt1)));
        waw = s.wr0 && s.wr1 && (s.rd0 == s.rd1) && (s.rd0 != 0);
        i1  = i0 && s.v1 && !s.br0 && !s.br1 && regReady(s.rs1) &&
              (!s.ut1 || regReady(s.rt1)) && !raw && !waw;

        e.i0 = i0; e.i1 = i1;
        e.cons = 2'(int'(i0) + int'(i1));
        e.ff = inFlush && s.rst;
        e.bsy = !running;
        e.stall = 16'(mStall);
        e.known = mKnown;
        expQ.push_back(e);

        if (!s.rst) begin
            foreach (readyAt[r]) readyAt[r] = 0;
            brCycle = -1;
            flushCycle = -1;
            mStall = 0;
            mKnown = 1'b1;
        end else begin
            if (s.v0 && !i0 && mStall < 65535) mStall++;
            if (i0 && s.wr0 && s.rd0 != 0) readyAt[s.rd0] = cyc + WB_LAT;
            if (i1 && s.wr1 && s.rd1 != 0) readyAt[s.rd1] = cyc + WB_LAT;
            if (inBrWait && (cyc == brCycle + BR_LAT) && s.bc) flushCycle = cyc + 1;
            if (i0 && s.br0) brCycle = cyc;
        end
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(idle());
    endtask

    // Monitor: compare whatever the model predicted against what the DUT shows
    // mid-cycle. Busy and stall count are undefined until the first reset.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("issue0", 16'(bus.issue0), 16'(e.i0));
                checkOutput("issue1", 16'(bus.issue1), 16'(e.i1));
                checkOutput("consumed", 16'(bus.consumed), 16'(e.cons));
                checkOutput("fetch_flush", 16'(bus.fetch_flush), 16'(e.ff));
                if (e.known) begin
                    checkOutput("busy", 16'(bus.busy), 16'(e.bsy));
                    checkOutput("stall_count", bus.stall_count, e.stall);
                end
                monCycle++;
            end
        end
    end

    // Saturation run: a taken branch every 6 cycles on the BR_LAT=4 instance
    // stalls slot 0 in 5 of every 6 cycles (4 BR_WAIT + 1 FLUSH).
    initial begin : saturation
        satRst_n = 1'b0;
        satBus.valid0 = 1'b0; satBus.valid1 = 1'b0;
        satBus.rs0 = 5'd1; satBus.rt0 = 5'd2; satBus.rd0 = 5'd0;
        satBus.rs1 = 5'd0; satBus.rt1 = 5'd0; satBus.rd1 = 5'd0;
        satBus.use_rt0 = 1'b1; satBus.use_rt1 = 1'b0;
        satBus.regwr0 = 1'b0; satBus.regwr1 = 1'b0;
        satBus.isbr0 = 1'b0; satBus.isbr1 = 1'b0;
        satBus.branch_ctrl = 1'b0;
        @(posedge clk);
        #1;
        satRst_n = 1'b0;
        @(posedge clk);
        #1;
        satRst_n = 1'b1;
        satBus.valid0 = 1'b1;
        satBus.isbr0 = 1'b1;
        satBus.branch_ctrl = 1'b1;
        repeat (6 * 13000) @(posedge clk);
        #1;
        checkOutput("sat_stall_65000", satBus.stall_count, 16'd65000);
        repeat (6 * 108) @(posedge clk);
        #1;
        checkOutput("sat_stall_max", satBus.stall_count, 16'hFFFF);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("sat_stall_hold", satBus.stall_count, 16'hFFFF);
        satDone = 1'b1;
    end

    initial begin : stimulus
        stim_t s;
        rst_n = 1'b0;
        bus.valid0 = 1'b0; bus.valid1 = 1'b0;
        bus.rs0 = '0; bus.rt0 = '0; bus.rd0 = '0;
        bus.rs1 = '0; bus.rt1 = '0; bus.rd1 = '0;
        bus.use_rt0 = 1'b0; bus.use_rt1 = 1'b0;
        bus.regwr0 = 1'b0; bus.regwr1 = 1'b0;
        bus.isbr0 = 1'b0; bus.isbr1 = 1'b0;
        bus.branch_ctrl = 1'b0;
        foreach (readyAt[r]) readyAt[r] = 0;

        $display("[TB] reset with valid work presented");
        s = pair(1, 3, 1, 2, 1, 6, 4, 5);
        s.rst = 1'b0;
        applyStimulus(s);
        applyStimulus(s);

        $display("[TB] independent pair");
        applyStimulus(pair(1, 3, 1, 2, 1, 6, 4, 5));
        idleCycles(3);

        $display("[TB] intra-pair RAW on r5");
        applyStimulus(pair(1, 5, 1, 2, 1, 8, 5, 4));
        for (int k = 0; k < 3; k++) applyStimulus(pair(1, 8, 5, 4, 0, 0, 0, 0));
        idleCycles(3);

        $display("[TB] intra-pair WAW on r7 and writes to r0");
        applyStimulus(pair(1, 7, 1, 2, 1, 7, 3, 4));
        idleCycles(3);
        applyStimulus(pair(1, 0, 1, 2, 1, 0, 3, 4));
        applyStimulus(pair(1, 9, 0, 0, 1, 10, 0, 1));
        idleCycles(3);

        $display("[TB] taken branch");
        s = pair(1, 0, 1, 2, 1, 11, 3, 4);
        s.br0 = 1'b1; s.wr0 = 1'b0;
        applyStimulus(s);
        for (int k = 1; k <= 4; k++) begin
            s = pair(1, 12, 1, 2, 1, 13, 3, 4);
            s.bc = (k == 2);
            applyStimulus(s);
        end
        idleCycles(3);

        $display("[TB] untaken branch with stray branch_ctrl pulse");
        s = pair(1, 0, 1, 2, 0, 0, 0, 0);
        s.br0 = 1'b1; s.wr0 = 1'b0;
        applyStimulus(s);
        for (int k = 1; k <= 4; k++) begin
            s = pair(1, 14, 1, 2, 1, 15, 3, 4);
            s.bc = (k == 1);
            applyStimulus(s);
        end
        idleCycles(3);

        $display("[TB] reset during BR_WAIT");
        s = pair(1, 9, 1, 2, 0, 0, 0, 0);
        s.br0 = 1'b1;
        applyStimulus(s);
        s = pair(1, 16, 9, 9, 0, 0, 0, 0);
        s.rst = 1'b0; s.bc = 1'b1;
        applyStimulus(s);
        s.rst = 1'b1;
        applyStimulus(s);
        s = idle();
        s.bc = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        idleCycles(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.rst = ($urandom_range(0, 63) != 0);
            s.v0 = ($urandom_range(0, 7) != 0);
            s.v1 = ($urandom_range(0, 3) != 0);
            s.rs0 = 5'($urandom_range(0, 7)); s.rt0 = 5'($urandom_range(0, 7));
            s.rd0 = 5'($urandom_range(0, 7)); s.rs1 = 5'($urandom_range(0, 7));
            s.rt1 = 5'($urandom_range(0, 7)); s.rd1 = 5'($urandom_range(0, 7));
            s.ut0 = 1'($urandom_range(0, 1)); s.ut1 = 1'($urandom_range(0, 1));
            s.wr0 = ($urandom_range(0, 3) != 0); s.wr1 = ($urandom_range(0, 3) != 0);
            s.br0 = ($urandom_range(0, 9) == 0); s.br1 = ($urandom_range(0, 9) == 0);
            s.bc = 1'($urandom_range(0, 1));
            applyStimulus(s);
        end
        idleCycles(2);

        for (int k = 0; k < 100000 && !satDone; k++) @(posedge clk);
        if (!satDone) begin
            errors++;
            $display("[TB] FAIL sat_timeout actual=not_done required=done");
        end
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
